// File: rtl/float_round_stage_if.sv
// Handshake and field bundle for the float rounding stage.
// slave is the rounding stage's view; master is the producer/consumer side.
interface float_round_stage_if #(
    parameter int EXP           = 8,
    parameter int FRAC          = 23,
    parameter int TRAILING_BITS = 2
);
    logic                     inValid;
    logic                     inReady;
    logic                     inSign;
    logic [EXP-1:0]           inExponent;
    logic [FRAC-1:0]          inFraction;
    logic [TRAILING_BITS-1:0] inTrailingBits;
    logic                     inStickyBit;
    logic                     inIsNan;
    logic [1:0]               roundMode;
    logic                     outValid;
    logic                     outReady;
    logic                     outSign;
    logic [EXP-1:0]           outExponent;
    logic [FRAC-1:0]          outFraction;
    logic                     outInexact;
    logic                     outOverflow;

    modport slave (
        input  inValid, inSign, inExponent, inFraction, inTrailingBits,
               inStickyBit, inIsNan, roundMode, outReady,
        output inReady, outValid, outSign, outExponent, outFraction,
               outInexact, outOverflow
    );

    modport master (
        output inValid, inSign, inExponent, inFraction, inTrailingBits,
               inStickyBit, inIsNan, roundMode, outReady,
        input  inReady, outValid, outSign, outExponent, outFraction,
               outInexact, outOverflow
    );
endinterface

// File: rtl/float_round_stage.sv
// Two-stage rounding of the adder's unrounded sum with valid/ready flow control.
// Define FLOAT_ROUND_DIRECTED_EN to honour roundMode (RTZ/RUP/RDN); otherwise RNE only.
module float_round_stage #(
    parameter int EXP           = 8,
    parameter int FRAC          = 23,
    parameter int TRAILING_BITS = 2
) (
    input  logic               clock,
    input  logic               reset,
    float_round_stage_if.slave bus
);
    localparam int W = EXP + FRAC;
    localparam logic [EXP-1:0]  EXP_ONES  = '1;
    localparam logic [EXP-1:0]  EXP_MAXF  = EXP_ONES - EXP'(1);
    localparam logic [FRAC-1:0] FRAC_ONES = '1;
    localparam logic [FRAC-1:0] NAN_FRAC  = {1'b1, {(FRAC-1){1'b0}}};

    logic s1Valid, s2Valid, s1Adv, s2Adv;
    logic s1Sign, s1Inc, s1Inexact, s1Special;
    logic [EXP-1:0]  s1Exp;
    logic [FRAC-1:0] s1Frac;

    assign s2Adv       = !s2Valid || bus.outReady;
    assign s1Adv       = !s1Valid || s2Adv;
    assign bus.inReady = s1Adv;
    assign bus.outValid = s2Valid;

    // Rounding decision from the raw input fields
    logic rBit, sBit, incNear, incEff, isInf;
    assign rBit    = bus.inTrailingBits[TRAILING_BITS-1];
    assign sBit    = (|bus.inTrailingBits[TRAILING_BITS-2:0]) | bus.inStickyBit;
    assign incNear = rBit & (sBit | bus.inFraction[0]);
    assign isInf   = (&bus.inExponent) & !bus.inIsNan;

`ifdef FLOAT_ROUND_DIRECTED_EN
    logic [1:0] s1Mode;
    logic       s1IncNear;
    always_comb begin
        incEff = incNear;
        case (bus.roundMode)
            2'd1:    incEff = 1'b0;
            2'd2:    incEff = !bus.inSign & (rBit | sBit);
            2'd3:    incEff = bus.inSign & (rBit | sBit);
            default: incEff = incNear;
        endcase
    end
`else
    logic unusedMode;
    assign unusedMode = ^bus.roundMode;
    assign incEff     = incNear;
`endif

    // S2: increment {exp, frac} as one value so fraction carry bumps the exponent
    logic [W-1:0]    sum;
    logic            ovf, sat;
    logic [EXP-1:0]  nExp;
    logic [FRAC-1:0] nFrac;
    assign sum = {s1Exp, s1Frac} + W'(s1Inc);

    always_comb begin
        sat = 1'b0;
        ovf = !s1Special && (&sum[W-1:FRAC]);
`ifdef FLOAT_ROUND_DIRECTED_EN
        sat = (s1Mode == 2'd1) || (s1Mode == 2'd2 && s1Sign) || (s1Mode == 2'd3 && !s1Sign);
        // Saturating modes never increment, so detect the would-be carry past max finite
        if (sat && !s1Special && s1IncNear && s1Exp == EXP_MAXF && (&s1Frac))
            ovf = 1'b1;
`endif
        nExp  = sum[W-1:FRAC];
        nFrac = sum[FRAC-1:0];
        if (ovf && sat) begin
            nExp  = EXP_MAXF;
            nFrac = FRAC_ONES;
        end else if (ovf) begin
            nExp  = EXP_ONES;
            nFrac = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid         <= 1'b0;
            s1Sign          <= 1'b0;
            s1Exp           <= '0;
            s1Frac          <= '0;
            s1Inc           <= 1'b0;
            s1Inexact       <= 1'b0;
            s1Special       <= 1'b0;
            s2Valid         <= 1'b0;
            bus.outSign     <= 1'b0;
            bus.outExponent <= '0;
            bus.outFraction <= '0;
            bus.outInexact  <= 1'b0;
            bus.outOverflow <= 1'b0;
`ifdef FLOAT_ROUND_DIRECTED_EN
            s1Mode          <= 2'd0;
            s1IncNear       <= 1'b0;
`endif
        end else begin
            if (s1Adv) s1Valid <= bus.inValid;
            if (s1Adv && bus.inValid) begin
`ifdef FLOAT_ROUND_DIRECTED_EN
                s1Mode    <= bus.roundMode;
                s1IncNear <= incNear;
`endif
                if (bus.inIsNan) begin
                    s1Sign    <= 1'b0;
                    s1Exp     <= EXP_ONES;
                    s1Frac    <= NAN_FRAC;
                    s1Inc     <= 1'b0;
                    s1Inexact <= 1'b0;
                    s1Special <= 1'b1;
                end else begin
                    s1Sign    <= bus.inSign;
                    s1Exp     <= bus.inExponent;
                    s1Frac    <= bus.inFraction;
                    s1Inc     <= isInf ? 1'b0 : incEff;
                    s1Inexact <= isInf ? 1'b0 : (rBit | sBit);
                    s1Special <= isInf;
                end
            end
            if (s2Adv) s2Valid <= s1Valid;
            if (s2Adv && s1Valid) begin
                bus.outSign     <= s1Sign;
                bus.outExponent <= nExp;
                bus.outFraction <= nFrac;
                bus.outInexact  <= s1Inexact;
                bus.outOverflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_float_round_stage.sv
// Directed-vector bench for float_round_stage (EXP=8, FRAC=23, TB=2).
module tb_float_round_stage;
    localparam int EXP = 8, FRAC = 23, TB = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    float_round_stage_if #(.EXP(EXP), .FRAC(FRAC), .TRAILING_BITS(TB)) bus();
    float_round_stage #(.EXP(EXP), .FRAC(FRAC), .TRAILING_BITS(TB)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] outWord;
    assign outWord = {bus.outSign, bus.outExponent, bus.outFraction};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] f,
                         input logic [1:0] t, input logic st, input logic nan, input logic [1:0] m);
        bus.inSign = s; bus.inExponent = e; bus.inFraction = f;
        bus.inTrailingBits = t; bus.inStickyBit = st; bus.inIsNan = nan; bus.roundMode = m;
    endtask

    task automatic runBeat(input string tag, input logic s, input logic [7:0] e, input logic [22:0] f,
                           input logic [1:0] t, input logic st, input logic nan, input logic [1:0] m,
                           input logic [31:0] w, input logic inx, input logic ovf);
        int n;
        @(negedge clock);
        drive(s, e, f, t, st, nan, m);
        bus.inValid = 1'b1;
        bus.outReady = 1'b1;
        @(posedge clock);
        #1 bus.inValid = 1'b0;
        n = 0;
        while (!bus.outValid && n < 8) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "/valid"}, bus.outValid, 1);
        chk({tag, "/word"}, outWord, w);
        chk({tag, "/inexact"}, bus.outInexact, inx);
        chk({tag, "/overflow"}, bus.outOverflow, ovf);
    endtask

    function automatic logic [31:0] streamWord(input int k);
        logic [22:0] f;
        f = 23'(k + (k & 1));
        return {1'b0, 8'(16 + k), f};
    endfunction

    initial begin
        int acc, got, early, n;
        logic [31:0] expQ[$];
        bus.inValid = 1'b0;
        bus.outReady = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst/outValid", bus.outValid, 0);
        chk("rst/word", outWord, 0);
        chk("rst/inexact", bus.outInexact, 0);
        chk("rst/overflow", bus.outOverflow, 0);
        chk("rst/inReady", bus.inReady, 1);

        runBeat("tieEven",   0, 8'h7F, 23'h000000, 2'b10, 0, 0, 0, 32'h3F800000, 1, 0);
        runBeat("tieOdd",    0, 8'h7F, 23'h000001, 2'b10, 0, 0, 0, 32'h3F800002, 1, 0);
        runBeat("below",     0, 8'h7F, 23'h000001, 2'b01, 0, 0, 0, 32'h3F800001, 1, 0);
        runBeat("stickyOnly",0, 8'h7F, 23'h000000, 2'b00, 1, 0, 0, 32'h3F800000, 1, 0);
        runBeat("exact",     1, 8'h80, 23'h123456, 2'b00, 0, 0, 0, 32'hC0123456, 0, 0);
        runBeat("carryExp",  0, 8'h7F, 23'h7FFFFF, 2'b11, 0, 0, 0, 32'h40000000, 1, 0);
        runBeat("denormPro", 0, 8'h00, 23'h7FFFFF, 2'b10, 0, 0, 0, 32'h00800000, 1, 0);
        runBeat("negZero",   1, 8'h00, 23'h000000, 2'b01, 0, 0, 0, 32'h80000000, 1, 0);
        runBeat("ovfRne",    0, 8'hFE, 23'h7FFFFF, 2'b10, 1, 0, 0, 32'h7F800000, 1, 1);
        runBeat("nan",       1, 8'h12, 23'h000345, 2'b11, 1, 1, 0, 32'h7FC00000, 0, 0);
        runBeat("negInf",    1, 8'hFF, 23'h000000, 2'b11, 1, 0, 0, 32'hFF800000, 0, 0);
`ifdef FLOAT_ROUND_DIRECTED_EN
        runBeat("ovfRtz",    0, 8'hFE, 23'h7FFFFF, 2'b10, 1, 0, 1, 32'h7F7FFFFF, 1, 1);
        runBeat("rtzTie",    0, 8'h7F, 23'h000001, 2'b10, 0, 0, 1, 32'h3F800001, 1, 0);
        runBeat("rupPos",    0, 8'h7F, 23'h000001, 2'b01, 0, 0, 2, 32'h3F800002, 1, 0);
        runBeat("rupNeg",    1, 8'h7F, 23'h000001, 2'b11, 0, 0, 2, 32'hBF800001, 1, 0);
        runBeat("rdnNeg",    1, 8'h7F, 23'h000001, 2'b01, 0, 0, 3, 32'hBF800002, 1, 0);
        runBeat("ovfRdnPos", 0, 8'hFE, 23'h7FFFFF, 2'b11, 0, 0, 3, 32'h7F7FFFFF, 1, 1);
        runBeat("ovfRupPos", 0, 8'hFE, 23'h7FFFFF, 2'b01, 0, 0, 2, 32'h7F800000, 1, 1);
`else
        runBeat("modeIgnored", 0, 8'h7F, 23'h000001, 2'b10, 0, 0, 1, 32'h3F800002, 1, 0);
`endif

        // Six back-to-back beats; consumer stalled for the first four cycles
        acc = 0; got = 0; early = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clock);
            bus.outReady = (cyc >= 4);
            if (acc < 6) begin
                drive(0, 8'(16 + acc), 23'(acc), 2'b10, 0, 0, 0);
                bus.inValid = 1'b1;
            end else begin
                bus.inValid = 1'b0;
            end
            #1;
            if (bus.outValid) begin
                chk("stream/word", outWord, (expQ.size() > 0) ? expQ[0] : 32'hDEADBEEF);
                if (bus.outReady && expQ.size() > 0) begin
                    void'(expQ.pop_front());
                    got++;
                end
            end
            if (bus.inValid && bus.inReady) begin
                expQ.push_back(streamWord(acc));
                acc++;
                if (cyc < 4) early++;
            end
        end
        bus.inValid = 1'b0;
        chk("stream/acceptedWhileStalled", early, 2);
        chk("stream/inCount", acc, 6);
        chk("stream/outCount", got, 6);

        // Reset with two beats in flight
        @(negedge clock);
        bus.outReady = 1'b0;
        drive(0, 8'h40, 23'h000010, 2'b00, 0, 0, 0);
        bus.inValid = 1'b1;
        @(posedge clock);
        #1 drive(0, 8'h41, 23'h000011, 2'b00, 0, 0, 0);
        @(posedge clock);
        #1 bus.inValid = 1'b0;
        @(negedge clock);
        chk("midRst/preValid", bus.outValid, 1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midRst/outValid", bus.outValid, 0);
        chk("midRst/word", outWord, 0);
        chk("midRst/inReady", bus.inReady, 1);
        bus.outReady = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus.outValid) n++;
        end
        chk("midRst/noGhostBeats", n, 0);
        runBeat("afterRst", 0, 8'h7F, 23'h000003, 2'b10, 0, 0, 0, 32'h3F800004, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
